stack16_ctrl: RTL and testbench
===============================

Name: stack16_ctrl

Overview:
Sequencer between the CPU execute stage and the synchronous 16-bit stack unit. It accepts PUSH/POP/CALL/RET operations over a valid/ready handshake and issues single-cycle push/pop pulses to the stack. It waits out the stack's sync-read pop latency and returns results over a valid/ready response channel. It also guards overflow/underflow with an occupancy counter and detects a lost pop_valid with a timeout.

Parameters:
DEPTH_MAX, 256, maximum stack occupancy in words; PUSH/CALL at this depth faults.
POP_TIMEOUT, 8, cycles spent in WAIT_POP without stk_pop_valid before timeout fault (1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  operation request valid
req_ready  out  1  controller can accept request
req_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
req_data  in  16  PUSH value / CALL return address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_op  out  2  echo of accepted req_op
rsp_data  out  16  popped word (POP/RET); echo of req_data (PUSH/CALL)
rsp_fault  out  2  00 ok, 01 overflow, 10 underflow, 11 pop timeout
stk_push  out  1  push pulse to stack unit, registered
stk_pop  out  1  pop pulse to stack unit, registered
stk_push_data  out  16  data for push
stk_pop_data  in  16  stack pop result
stk_pop_valid  in  1  stack pop result valid (1-cycle pulse)
depth  out  clog2(DEPTH_MAX+1)  current occupancy
fault_sticky  out  1  set on any fault, cleared by fault_clr
fault_clr  in  1  clears fault_sticky

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0 while rst=1; all other outputs 0, including depth and fault_sticky.
- States: IDLE, ISSUE, WAIT_POP, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op and data.
  - PUSH/CALL with depth==DEPTH_MAX: go to RESP with fault 01. No stack pulse.
  - POP/RET with depth==0: go to RESP with fault 10, rsp_data=0. No stack pulse.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle): the registered pulse output is high during this cycle.
  - PUSH/CALL: stk_push=1, stk_push_data=latched data, depth+1 at cycle end. Next state RESP.
  - POP/RET: stk_pop=1, depth-1 at cycle end. Next state WAIT_POP.
  - stk_push and stk_pop are never both 1; both are 0 in every other state.
- WAIT_POP: timeout counter starts at 0 and increments each cycle.
  - On stk_pop_valid: capture stk_pop_data into rsp_data, go to RESP, fault 00.
  - If the counter reaches POP_TIMEOUT-1 without stk_pop_valid: go to RESP, fault 11, rsp_data=0. depth stays decremented.
  - stk_pop_valid in any other state is ignored.
- RESP: rsp_valid=1 with rsp_op, rsp_data and rsp_fault held stable until rsp_ready, then return to IDLE. req_ready=0.
- Latency with rsp_ready tied 1 and accept in cycle A:
  - PUSH/CALL: stk_push in A+1, rsp_valid in A+2, next accept A+3.
  - POP/RET: stk_pop in A+1, stk_pop_valid in A+3, rsp_valid in A+4.
  - Faulted requests: rsp_valid in A+1.
- fault_sticky: set in the cycle RESP is entered with a nonzero fault. fault_clr clears it; set wins if both happen in the same cycle.
- depth never wraps: overflow/underflow checks precede any update.
- Reset mid-operation: all state is dropped and no response is produced. The stack unit must be reset by the same top-level reset event, keeping depth consistent with the stack's SP.

Test Plan:
1. Reset, then PUSH 0x1234 accepted at cycle A -> stk_push=1, stk_push_data=0x1234 at A+1; rsp_valid at A+2 with rsp_data=0x1234, fault 00; depth=1.
2. PUSH 0xAAAA, CALL 0x0100, RET, POP against stack model -> RET returns 0x0100 (rsp_op 11) at accept+4, POP returns 0xAAAA; depth ends 0.
3. POP with depth=0 -> rsp_valid next cycle, fault 10, no stk_pop pulse, fault_sticky=1; fault_clr pulse -> fault_sticky=0.
4. DEPTH_MAX=4: five PUSHes -> first four ok with depth=4; fifth gets fault 01, no stk_push, depth stays 4.
5. POP with stack model suppressing stk_pop_valid -> fault 11 after POP_TIMEOUT=8 cycles in WAIT_POP, rsp_data=0, depth decremented.
6. Hold rsp_ready=0 for 5 cycles during a POP response -> rsp_valid and rsp_data stable, req_ready=0; assert rst mid-WAIT_POP -> outputs 0 immediately, no response.

Source files
------------

// File: rtl/stack16_ctrl.sv
// Sequencer between the execute stage and a sync-read 16-bit stack unit.
// Turns PUSH/POP/CALL/RET requests into stack pulses, guards depth and pop timeout.
module stack16_ctrl #(
  parameter int DEPTH_MAX   = 256,
  parameter int POP_TIMEOUT = 8,
  localparam int DW = $clog2(DEPTH_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [15:0]   req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_op,
  output logic [15:0]   rsp_data,
  output logic [1:0]    rsp_fault,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [15:0]   stk_push_data,
  input  logic [15:0]   stk_pop_data,
  input  logic          stk_pop_valid,
  output logic [DW-1:0] depth,
  output logic          fault_sticky,
  input  logic          fault_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_POP, RESP} state_t;

  localparam logic [DW-1:0] DMAX   = DW'(DEPTH_MAX);
  localparam logic [3:0]    TMO_LAST = 4'(POP_TIMEOUT - 1);

  state_t     state;
  logic [3:0] tmo;
  logic       req_is_push;

  // op[0]==0 selects the push-type ops (PUSH, CALL)
  assign req_is_push = ~req_op[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_op        <= 2'b00;
      rsp_data      <= 16'h0000;
      rsp_fault     <= 2'b00;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_push_data <= 16'h0000;
      depth         <= '0;
      fault_sticky  <= 1'b0;
      tmo           <= 4'd0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      if (fault_clr) fault_sticky <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_op    <= req_op;
            if (req_is_push && depth == DMAX) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_fault    <= 2'b01;
              rsp_data     <= req_data;
              fault_sticky <= 1'b1;
            end else if (!req_is_push && depth == '0) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_fault    <= 2'b10;
              rsp_data     <= 16'h0000;
              fault_sticky <= 1'b1;
            end else begin
              state     <= ISSUE;
              rsp_fault <= 2'b00;
              rsp_data  <= req_is_push ? req_data : 16'h0000;
              if (req_is_push) begin
                stk_push      <= 1'b1;
                stk_push_data <= req_data;
              end else begin
                stk_pop <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (!rsp_op[0]) begin
            depth     <= depth + 1'b1;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            depth <= depth - 1'b1;
            state <= WAIT_POP;
            tmo   <= 4'd0;
          end
        end
        WAIT_POP: begin
          if (stk_pop_valid) begin
            rsp_data  <= stk_pop_data;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else if (tmo == TMO_LAST) begin
            // lost pop_valid: the stack already moved SP, so depth stays decremented
            rsp_data     <= 16'h0000;
            rsp_fault    <= 2'b11;
            state        <= RESP;
            rsp_valid    <= 1'b1;
            fault_sticky <= 1'b1;
          end else begin
            tmo <= tmo + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack16_ctrl.sv
// Directed bench for stack16_ctrl with a 2-cycle sync-read stack model.
module tb_stack16_ctrl;
  localparam int DEPTH_MAX = 4;
  localparam int POP_TIMEOUT = 8;
  localparam int DW = $clog2(DEPTH_MAX + 1);

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b1, fault_clr = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [15:0] req_data = 16'h0;
  logic req_ready, rsp_valid, stk_push, stk_pop, stk_pop_valid, fault_sticky;
  logic [1:0] rsp_op, rsp_fault;
  logic [15:0] rsp_data, stk_push_data, stk_pop_data;
  logic [DW-1:0] depth;

  int checks = 0, errors = 0;
  int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
  int p0, q0;
  logic suppress = 1'b0;

  stack16_ctrl #(.DEPTH_MAX(DEPTH_MAX), .POP_TIMEOUT(POP_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_fault(rsp_fault), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_push_data(stk_push_data), .stk_pop_data(stk_pop_data),
    .stk_pop_valid(stk_pop_valid), .depth(depth), .fault_sticky(fault_sticky),
    .fault_clr(fault_clr));

  always #5 clk = ~clk;

  // stack model: pop result appears two cycles after the pop pulse
  logic [15:0] mem [16];
  logic [4:0]  sp;
  logic        pv1;
  logic [15:0] pd1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 5'd0; pv1 <= 1'b0; pd1 <= 16'h0;
      stk_pop_valid <= 1'b0; stk_pop_data <= 16'h0;
    end else begin
      pv1 <= stk_pop;
      if (stk_push) begin
        mem[sp[3:0]] <= stk_push_data;
        sp <= sp + 5'd1;
      end
      if (stk_pop) begin
        pd1 <= mem[sp[3:0] - 4'd1];
        sp  <= sp - 5'd1;
      end
      stk_pop_valid <= pv1 & ~suppress;
      stk_pop_data  <= pv1 ? pd1 : 16'h0;
    end
  end

  always @(posedge clk) begin
    if (stk_push === 1'b1) push_cnt++;
    if (stk_pop === 1'b1) pop_cnt++;
    if (stk_push === 1'b1 && stk_pop === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request with rsp_ready high, check latency and response fields
  task automatic run(input string tag, input logic [1:0] op, input logic [15:0] d,
                     input int lat, input logic [15:0] ed, input logic [1:0] ef, input int edep);
    int n;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_data = d;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".rsp_op"}, 32'(rsp_op), 32'(op));
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(ed));
    chk({tag, ".rsp_fault"}, 32'(rsp_fault), 32'(ef));
    chk({tag, ".depth"}, 32'(depth), 32'(edep));
    tick();
  endtask

  initial begin
    #3;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.depth", 32'(depth), 32'd0);
    chk("rst.fault_sticky", 32'(fault_sticky), 32'd0);
    chk("rst.pulses", {30'd0, stk_push, stk_pop}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single PUSH, cycle-by-cycle
    chk("t1.req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = 2'b00; req_data = 16'h1234;
    tick();
    req_valid = 1'b0;
    chk("t1.stk_push", 32'(stk_push), 32'd1);
    chk("t1.stk_pop", 32'(stk_pop), 32'd0);
    chk("t1.stk_push_data", 32'(stk_push_data), 32'h1234);
    chk("t1.req_ready_busy", 32'(req_ready), 32'd0);
    tick();
    chk("t1.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1.rsp_data", 32'(rsp_data), 32'h1234);
    chk("t1.rsp_fault", 32'(rsp_fault), 32'd0);
    chk("t1.depth", 32'(depth), 32'd1);
    chk("t1.stk_push_off", 32'(stk_push), 32'd0);
    tick();
    chk("t1.rsp_done", 32'(rsp_valid), 32'd0);

    // 2: push/call/ret/pop against the stack model
    run("t2.push", 2'b00, 16'hAAAA, 2, 16'hAAAA, 2'b00, 2);
    run("t2.call", 2'b10, 16'h0100, 2, 16'h0100, 2'b00, 3);
    run("t2.ret",  2'b11, 16'h0000, 4, 16'h0100, 2'b00, 2);
    run("t2.pop",  2'b01, 16'h0000, 4, 16'hAAAA, 2'b00, 1);
    run("t2.pop2", 2'b01, 16'h0000, 4, 16'h1234, 2'b00, 0);

    // 3: underflow
    p0 = pop_cnt;
    run("t3.underflow", 2'b01, 16'h5555, 1, 16'h0000, 2'b10, 0);
    chk("t3.no_pop", 32'(pop_cnt), 32'(p0));
    chk("t3.sticky", 32'(fault_sticky), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t3.sticky_clr", 32'(fault_sticky), 32'd0);

    // 4: fill to DEPTH_MAX then overflow
    run("t4.push1", 2'b00, 16'h4001, 2, 16'h4001, 2'b00, 1);
    run("t4.push2", 2'b00, 16'h4002, 2, 16'h4002, 2'b00, 2);
    run("t4.push3", 2'b10, 16'h4003, 2, 16'h4003, 2'b00, 3);
    run("t4.push4", 2'b00, 16'h4004, 2, 16'h4004, 2'b00, 4);
    q0 = push_cnt;
    run("t4.overflow", 2'b00, 16'h4005, 1, 16'h4005, 2'b01, 4);
    chk("t4.no_push", 32'(push_cnt), 32'(q0));
    chk("t4.sticky", 32'(fault_sticky), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;

    // 5: lost pop_valid -> timeout
    suppress = 1'b1;
    run("t5.timeout", 2'b01, 16'h0000, 2 + POP_TIMEOUT, 16'h0000, 2'b11, 3);
    suppress = 1'b0;
    chk("t5.sticky", 32'(fault_sticky), 32'd1);

    // 6: response backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'h0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t6.rsp_data", 32'(rsp_data), 32'h4003);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6.hold_valid", 32'(rsp_valid), 32'd1);
      chk("t6.hold_data", 32'(rsp_data), 32'h4003);
      chk("t6.hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t6.released", 32'(rsp_valid), 32'd0);
    chk("t6.depth", 32'(depth), 32'd2);
    tick();

    // 6b: reset while waiting for the pop result
    req_valid = 1'b1; req_op = 2'b01;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t6.rst_depth", 32'(depth), 32'd0);
    chk("t6.rst_ready", 32'(req_ready), 32'd0);
    chk("t6.rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6.rst_sticky", 32'(fault_sticky), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6.no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("t6.idle_ready", 32'(req_ready), 32'd1);
    chk("both_pulses", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
